// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FLUSH   = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5
  } loader_state_e;

  // Byte address of word slot 'slot' relative to 'base', wrapping modulo 2^32.
  function automatic logic [31:0] slot_addr(input logic [31:0] base, input logic [31:0] slot);
    return base + {slot[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_boot_loader_release_ctr.sv
// Loadable down-counter with a zero flag; times the core-reset release delay.
module loader_release_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         tick_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams instruction words into instruction memory and holds the core in
// reset until the last word is written plus a fixed release delay.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH_W     = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               imem_we,
  output logic [31:0]        imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_rst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DEPTH_W:0]   word_count
);

  localparam logic [DEPTH_W:0] FULL_CNT = {1'b1, {DEPTH_W{1'b0}}};

  loader_state_e      state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               core_rst_q, core_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DEPTH_W:0]   cnt_q, cnt_d;

  logic accept;
  logic ctr_load, ctr_tick, ctr_zero;

  // in_ready_q is only ever high in LOAD, so it alone qualifies acceptance.
  assign accept = in_valid && in_ready_q;

  loader_release_ctr #(
    .W(4)
  ) u_release_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ctr_load),
    .tick_i (ctr_tick),
    .val_i  (4'(RELEASE_DLY)),
    .zero_o (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ctr_load = 1'b0;
    ctr_tick = 1'b0;

    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == FULL_CNT) begin
            state_d = ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = slot_addr(BASE_ADDR, 32'(cnt_q));
            wdata_d = in_data;
            cnt_d   = cnt_q + 1'b1;
            if (in_last) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d  = RELEASE;
        ctr_load = 1'b1;
      end
      RELEASE: begin
        if (ctr_zero) state_d = RUN;
        else          ctr_tick = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered views of the state being entered.
    in_ready_d = (state_d == LOAD);
    core_rst_d = (state_d != RUN);
    busy_d     = (state_d == LOAD) || (state_d == FLUSH) || (state_d == RELEASE);
    done_d     = (state_d == RUN);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: full-depth instance for sessions, a 4-word
// instance for overflow and last-slot behaviour.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_start, in_valid, in_last;
  logic [31:0] in_data;

  logic        in_ready, imem_we, core_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [10:0] word_count;

  logic        s_in_ready, s_imem_we, s_core_rst, s_busy, s_done, s_err;
  logic [31:0] s_imem_addr, s_imem_wdata;
  logic [2:0]  s_word_count;

  imem_boot_loader #(.DEPTH_W(10), .BASE_ADDR(32'h0000_0000), .RELEASE_DLY(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  imem_boot_loader #(.DEPTH_W(2), .BASE_ADDR(32'h0000_0000), .RELEASE_DLY(4)) dut_s (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(s_in_ready), .imem_we(s_imem_we),
    .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .core_rst(s_core_rst),
    .busy(s_busy), .done(s_done), .err(s_err), .word_count(s_word_count)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] words[$];
  logic [31:0] model_mem[int];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load session on the full-depth instance. Expectations follow from the
  // rules: write visible the cycle after each acceptance at 4*index, core
  // reset falls 6 cycles after the final acceptance (1 write + 1 flush + 4).
  task automatic do_session(input int n, input int mode, input string tag);
    int idx, cyc;
    logic v;
    model_mem.delete();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1; load_start = 1'b1;
    step();
    load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_start_ready: got %b want 1", tag, in_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL %s_start_we: got %b want 0", tag, imem_we); end
    total++; if (word_count !== 11'd0) begin bad++; $display("FAIL %s_start_cnt: got %0d want 0", tag, word_count); end
    total++; if (core_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s_start_status: got rst=%b done=%b busy=%b want 1 0 1", tag, core_rst, done, busy);
    end
    idx = 0; cyc = 0;
    while (idx < n && cyc < 400) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      in_valid   = v;
      in_data    = v ? words[idx] : $urandom;
      in_last    = v ? (idx == n - 1) : 1'($urandom_range(0, 1));
      load_start = (mode == 2) && ($urandom_range(0, 3) == 0);
      step();
      total++; if (imem_we !== v) begin bad++; $display("FAIL %s_we[%0d]: got %b want %b", tag, cyc, imem_we, v); end
      if (v) begin
        model_mem[idx] = words[idx];
        total++; if (imem_addr !== 32'(idx * 4)) begin bad++; $display("FAIL %s_addr[%0d]: got %h want %h", tag, idx, imem_addr, 32'(idx * 4)); end
        total++; if (imem_wdata !== model_mem[idx]) begin bad++; $display("FAIL %s_data[%0d]: got %h want %h", tag, idx, imem_wdata, model_mem[idx]); end
        idx++;
      end
      total++; if (word_count !== 11'(idx)) begin bad++; $display("FAIL %s_cnt[%0d]: got %0d want %0d", tag, cyc, word_count, idx); end
      total++; if (in_ready !== (idx < n)) begin bad++; $display("FAIL %s_ready[%0d]: got %b want %b", tag, cyc, in_ready, idx < n); end
      total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL %s_hold[%0d]: got %b want 1", tag, cyc, core_rst); end
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0;
    total++; if (idx != n) begin bad++; $display("FAIL %s_timeout: got %0d words want %0d", tag, idx, n); end
    for (int j = 1; j <= 8; j++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = $urandom;
      load_start = (mode == 2) && (j <= 4) && ($urandom_range(0, 1) == 1);
      step();
      load_start = 1'b0;
      total++; if (core_rst !== (j < 6) || done !== (j >= 6) || busy !== (j < 6)) begin
        bad++; $display("FAIL %s_release[%0d]: got rst=%b done=%b busy=%b want %b %b %b", tag, j, core_rst, done, busy, j < 6, j >= 6, j < 6);
      end
      total++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || word_count !== 11'(n)) begin
        bad++; $display("FAIL %s_quiet[%0d]: got we=%b rdy=%b cnt=%0d want 0 0 %0d", tag, j, imem_we, in_ready, word_count, n);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (core_rst !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL reset_idle[%0d]: got rst=%b rdy=%b we=%b done=%b want 1 0 0 0", i, core_rst, in_ready, imem_we, done);
      end
      total++; if (busy !== 1'b0 || err !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 || word_count !== 11'd0) begin
        bad++; $display("FAIL reset_vals[%0d]: got busy=%b err=%b addr=%h wd=%h cnt=%0d want 0 0 0 0 0", i, busy, err, imem_addr, imem_wdata, word_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    words = {32'h00500093, 32'h00a00113, 32'h002081b3};
    do_session(3, 0, "b2b");
  endtask

  task automatic test_gaps();
    words = {$urandom, $urandom, $urandom};
    do_session(3, 1, "gaps");
  endtask

  task automatic test_reload();
    total++; if (done !== 1'b1 || core_rst !== 1'b0) begin
      bad++; $display("FAIL reload_pre: got done=%b rst=%b want 1 0", done, core_rst);
    end
    words = {$urandom};
    do_session(1, 0, "reload");
  endtask

  task automatic test_random();
    for (int s = 0; s < 5; s++) begin
      int n;
      n = $urandom_range(1, 12);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      do_session(n, 2, "rand");
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    rst = 1'b1; step(); rst = 1'b0;
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      in_valid = 1'b1; in_data = d; in_last = 1'b0;
      step();
      if (i < 4) begin
        total++; if (s_imem_we !== 1'b1 || s_imem_addr !== 32'(i * 4) || s_imem_wdata !== d) begin
          bad++; $display("FAIL ovf_write[%0d]: got we=%b addr=%h data=%h want 1 %h %h", i, s_imem_we, s_imem_addr, s_imem_wdata, 32'(i * 4), d);
        end
        total++; if (s_word_count !== 3'(i + 1) || s_err !== 1'b0) begin
          bad++; $display("FAIL ovf_cnt[%0d]: got cnt=%0d err=%b want %0d 0", i, s_word_count, s_err, i + 1);
        end
      end else begin
        total++; if (s_imem_we !== 1'b0 || s_err !== 1'b1 || s_core_rst !== 1'b1 || s_in_ready !== 1'b0 || s_word_count !== 3'd4) begin
          bad++; $display("FAIL ovf_err: got we=%b err=%b rst=%b rdy=%b cnt=%0d want 0 1 1 0 4", s_imem_we, s_err, s_core_rst, s_in_ready, s_word_count);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom_range(0, 1));
      step();
      total++; if (s_err !== 1'b1 || s_imem_we !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
        bad++; $display("FAIL ovf_sticky[%0d]: got err=%b we=%b busy=%b done=%b want 1 0 0 0", i, s_err, s_imem_we, s_busy, s_done);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; load_start = 1'b1;
    step();
    load_start = 1'b0;
    total++; if (s_err !== 1'b0 || s_word_count !== 3'd0 || s_in_ready !== 1'b1 || s_core_rst !== 1'b1) begin
      bad++; $display("FAIL ovf_restart: got err=%b cnt=%0d rdy=%b rst=%b want 0 0 1 1", s_err, s_word_count, s_in_ready, s_core_rst);
    end
    // Filling every slot exactly, with in_last on the final one, is legal.
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      in_valid = 1'b1; in_data = d; in_last = (i == 3);
      step();
      total++; if (s_imem_we !== 1'b1 || s_imem_addr !== 32'(i * 4) || s_imem_wdata !== d) begin
        bad++; $display("FAIL lastslot_write[%0d]: got we=%b addr=%h data=%h want 1 %h %h", i, s_imem_we, s_imem_addr, s_imem_wdata, 32'(i * 4), d);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step();
      total++; if (s_core_rst !== (j < 6) || s_done !== (j >= 6) || s_err !== 1'b0) begin
        bad++; $display("FAIL lastslot_release[%0d]: got rst=%b done=%b err=%b want %b %b 0", j, s_core_rst, s_done, s_err, j < 6, j >= 6);
      end
    end
  endtask

  task automatic test_rst_midload();
    load_start = 1'b1; step(); load_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h1111_2222; in_last = 1'b0;
    step();
    total++; if (imem_we !== 1'b1 || imem_wdata !== 32'h1111_2222) begin
      bad++; $display("FAIL rstmid_first: got we=%b data=%h want 1 11112222", imem_we, imem_wdata);
    end
    in_data = 32'h3333_4444; rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || core_rst !== 1'b1 || word_count !== 11'd0) begin
      bad++; $display("FAIL rstmid_drop: got we=%b rdy=%b rst=%b cnt=%0d want 0 0 1 0", imem_we, in_ready, core_rst, word_count);
    end
    total++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rstmid_vals: got addr=%h wd=%h busy=%b done=%b err=%b want 0 0 0 0 0", imem_addr, imem_wdata, busy, done, err);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom_range(0, 1));
      step();
      total++; if (in_ready !== 1'b0 || imem_we !== 1'b0 || word_count !== 11'd0 || core_rst !== 1'b1) begin
        bad++; $display("FAIL rstmid_idle[%0d]: got rdy=%b we=%b cnt=%0d rst=%b want 0 0 0 1", i, in_ready, imem_we, word_count, core_rst);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_reload();
    test_random();
    test_overflow();
    test_rst_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
